dcache_ctrl: RTL
================

# dcache_ctrl

Data-cache responder serving the MEM stage's `dc_*` request interface: accepts one load or store at a time, returns the aligned doubleword for loads and a completion pulse for stores. Direct-mapped, write-through, no-write-allocate; misses refill a full line from the memory port. It sits between the MEM stage and the memory interconnect. It also serves atomic read-then-write sequences, which arrive as two back-to-back requests to the same address.

## Interface
- `SETS`, 64: number of lines, power of two.
- `LINE_WORDS`, 8: 64-bit words per line (64-byte line).
- `ADDR_WIDTH`, 64: address width.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `dc_en`  in  1  request valid; held with stable fields until completion.
- `dc_in_addr`  in  64  byte address; naturally aligned to the access size.
- `dc_write_en`  in  1  1 = store, 0 = load.
- `dc_in_wdata`  in  64  store data, LSB-justified (not pre-shifted).
- `dc_in_wlen`  in  2  log2(bytes): 0 = B, 1 = H, 2 = W, 3 = D.
- `dc_out_rdata`  out  64  aligned doubleword containing the load address.
- `dc_out_rvalid`  out  1  one-cycle load-completion pulse.
- `dc_out_write_done`  out  1  one-cycle store-completion pulse.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_write`  out  1  1 = write, 0 = line read.
- `mem_req_addr`  out  64  line-aligned for reads; doubleword-aligned for writes.
- `mem_req_wdata`  out  64  write data, already shifted into byte lanes.
- `mem_req_wstrb`  out  8  byte enables for a write.
- `mem_rvalid`  in  1  one fill beat per assertion, words 0..LINE_WORDS-1 in order.
- `mem_rdata`  in  64  fill beat data.
- `mem_wack`  in  1  write completed at memory.

## Operation
- Address split: offset[2:0], word[log2(LINE_WORDS)+2:3], index of log2(SETS) bits, tag = remaining upper bits.
- Request capture: in IDLE with `dc_en`=1, register addr, write_en, wdata and wlen; go to LOOKUP.
- Store lane and strobe formation: lane shift = addr[2:0]*8. wstrb = ((1<<(1<<wlen))-1) << addr[2:0].
- LOOKUP, load hit: latch the word into the rdata register; go to RESP.
- LOOKUP, load miss: go to FILL_REQ.
- LOOKUP, store (hit or miss): on a hit, merge the strobed bytes into the array word in this cycle; the line stays valid. Go to WR_REQ.
- FILL_REQ: hold `mem_req_valid`=1, read, line address, until `mem_req_ready`; go to FILL_DATA.
- FILL_DATA: write each beat into the array, using a beat counter of log2(LINE_WORDS) bits. Latch the beat whose index equals the request word.
  - After the last beat, set valid and tag; go to RESP.
  - The load is answered only after the whole line is in the array.
- WR_REQ: hold a write request (shifted wdata, wstrb, doubleword address) until `mem_req_ready`; go to WR_WAIT.
- WR_WAIT: on `mem_wack`, go to RESP.
- RESP: pulse `dc_out_rvalid` for a load or `dc_out_write_done` for a store; go to IDLE.
- No back-to-back requests: `dc_en` in RESP is ignored. IDLE samples the next request in the following cycle. This covers atomic load-then-store and a requester still stalled for another reason.
- Natural alignment violation (addr[2:0] not a multiple of the size) raises a simulation `$error`. The access proceeds with the computed strobe, truncated to 8 bits.

## Timing
- Load hit: request seen in IDLE at cycle N; LOOKUP at N+1; `dc_out_rvalid` at N+2.
- Load miss: N+2 → FILL_REQ; memory latency plus LINE_WORDS beats; then RESP one cycle after the last beat.
- Store: `dc_out_write_done` one cycle after `mem_wack`.
- Outputs:
  - `dc_out_rvalid`, `dc_out_write_done`, `dc_out_rdata` and `mem_req_valid` are registered.
  - The `mem_req_*` fields are stable while `mem_req_valid`=1.
- Reset values: all outputs 0, state IDLE, every valid bit cleared, beat counter 0.
- Reset asserted mid-fill or mid-write aborts the operation with no completion pulse. The memory side is reset together with this block; stray beats arriving in IDLE are ignored.
- `mem_wack` or `mem_rvalid` outside WR_WAIT / FILL_DATA is ignored.

## Structure
- Shared package `dcache_pkg` holds:
  - the state enum `dc_state_t` (IDLE, LOOKUP, FILL_REQ, FILL_DATA, WR_REQ, WR_WAIT, RESP);
  - wlen encodings (WLEN_B/H/W/D);
  - the strobe/shift helper function.
- Sub-module `dcache_array`: tag, valid and data storage. It provides a combinational read port, a one-word write port with byte enables, and a line-valid set/clear-all port.

## Test plan
- Load hit: fill line at 0x1000 with words 0x11..0x88; load D at 0x1008 → `dc_out_rvalid` 2 cycles after `dc_en`, rdata=0x22, no `mem_req_valid`.
- Load miss: empty cache, load at 0x2038 → one read request at 0x2000, 8 beats, rvalid after the last beat with beat 7 data; a reload of the same address then hits.
- Store byte on a hit: `dc_in_addr`=0x1003, wlen=0, wdata=0xAB → mem wstrb=0x08, wdata[31:24]=0xAB, write_done after `mem_wack`; a load at 0x1000 returns 0x11 with byte 3 replaced by 0xAB.
- Store miss: store to an uncached line → memory write issued, line stays invalid, and the next load to it misses.
- Atomic pair: `dc_en` held through a load then a store at the same address → rvalid and write_done each pulse exactly once, separated by one or more idle cycles.
- Reset mid-fill: assert reset at beat 3 → outputs drop to 0, no rvalid, the line is invalid, and the next request starts from IDLE.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the write-through data cache responder.
package dcache_pkg;

  localparam int DATA_W = 64;
  localparam int BYTES  = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL_REQ,
    FILL_DATA,
    WR_REQ,
    WR_WAIT,
    RESP
  } dc_state_t;

  localparam logic [1:0] WLEN_B = 2'd0;
  localparam logic [1:0] WLEN_H = 2'd1;
  localparam logic [1:0] WLEN_W = 2'd2;
  localparam logic [1:0] WLEN_D = 2'd3;

  // Byte enables for an access of 2**wlen bytes at byte offset off; bits
  // that would spill past the doubleword are dropped.
  function automatic logic [BYTES-1:0] lane_strobe(input logic [1:0] wlen,
                                                   input logic [2:0] off);
    logic [15:0] full;
    full = ((16'd1 << (5'd1 << wlen)) - 16'd1) << off;
    return full[BYTES-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] lane_shift(input logic [DATA_W-1:0] wdata,
                                                   input logic [2:0] off);
    return wdata << {off, 3'b000};
  endfunction

  function automatic logic misaligned(input logic [1:0] wlen, input logic [2:0] off);
    logic [2:0] mask;
    mask = (3'd1 << wlen) - 3'd1;
    return (off & mask) != 3'd0;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage for a direct-mapped cache: combinational read,
// one-word byte-enabled write, per-line valid set/clear and clear-all.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 8,
  parameter int TAG_W      = 52,
  localparam int IDX_W     = $clog2(SETS),
  localparam int WORD_W    = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [WORD_W-1:0] rd_word,
  output logic [DATA_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BYTES-1:0]  wr_be,
  input  logic              line_set,
  input  logic              line_clr,
  input  logic              clr_all,
  input  logic [IDX_W-1:0]  line_index,
  input  logic [TAG_W-1:0]  line_tag
);

  logic [SETS-1:0]         valid_q;
  logic [SETS-1:0]         valid_d;
  logic [TAG_W-1:0]        tag_mem [SETS];
  logic [IDX_W+WORD_W-1:0] rd_addr;
  logic [IDX_W+WORD_W-1:0] wr_addr;

  assign rd_addr  = {rd_index, rd_word};
  assign wr_addr  = {wr_index, wr_word};
  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_q[rd_index];

  always_comb begin
    valid_d = valid_q;
    if (clr_all) begin
      valid_d = '0;
    end else if (line_clr) begin
      valid_d[line_index] = 1'b0;
    end else if (line_set) begin
      valid_d[line_index] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (line_set) begin
      tag_mem[line_index] <= line_tag;
    end
  end

  // One narrow memory per byte lane so the byte enables map onto plain writes.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    logic [7:0] lane_mem [SETS*LINE_WORDS];

    always_ff @(posedge clk) begin
      if (wr_en && wr_be[gi]) begin
        lane_mem[wr_addr] <= wr_data[gi*8 +: 8];
      end
    end

    assign rd_data[gi*8 +: 8] = lane_mem[rd_addr];
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache serving one
// MEM-stage load or store at a time; misses refill a full line.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dc_en,
  input  logic [ADDR_WIDTH-1:0] dc_in_addr,
  input  logic                  dc_write_en,
  input  logic [DATA_W-1:0]     dc_in_wdata,
  input  logic [1:0]            dc_in_wlen,
  output logic [DATA_W-1:0]     dc_out_rdata,
  output logic                  dc_out_rvalid,
  output logic                  dc_out_write_done,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [BYTES-1:0]      mem_req_wstrb,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_wack
);

  localparam int WORD_W  = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int WORD_LSB = 3;
  localparam int IDX_LSB = WORD_LSB + WORD_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

  dc_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [1:0]            wlen_q, wlen_d;
  logic [WORD_W-1:0]     beat_q, beat_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  wdone_q, wdone_d;
  logic                  req_valid_q, req_valid_d;
  logic                  req_write_q, req_write_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0]     req_wdata_q, req_wdata_d;
  logic [BYTES-1:0]      req_wstrb_q, req_wstrb_d;

  logic [WORD_W-1:0]     word_sel;
  logic [IDX_W-1:0]      idx_sel;
  logic [TAG_W-1:0]      tag_sel;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic [ADDR_WIDTH-1:0] dw_addr;
  logic [DATA_W-1:0]     st_data;
  logic [BYTES-1:0]      st_be;
  logic                  hit;

  logic [DATA_W-1:0]     arr_rd_data;
  logic [TAG_W-1:0]      arr_rd_tag;
  logic                  arr_rd_valid;
  logic                  arr_wr_en;
  logic [WORD_W-1:0]     arr_wr_word;
  logic [DATA_W-1:0]     arr_wr_data;
  logic [BYTES-1:0]      arr_wr_be;
  logic                  arr_line_set;
  logic                  arr_line_clr;

  assign word_sel  = addr_q[IDX_LSB-1:WORD_LSB];
  assign idx_sel   = addr_q[TAG_LSB-1:IDX_LSB];
  assign tag_sel   = addr_q[ADDR_WIDTH-1:TAG_LSB];
  assign line_addr = {addr_q[ADDR_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
  assign dw_addr   = {addr_q[ADDR_WIDTH-1:WORD_LSB], {WORD_LSB{1'b0}}};
  assign st_data   = lane_shift(wdata_q, addr_q[2:0]);
  assign st_be     = lane_strobe(wlen_q, addr_q[2:0]);
  assign hit       = arr_rd_valid && (arr_rd_tag == tag_sel);

  dcache_array #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .rd_index   (idx_sel),
    .rd_word    (word_sel),
    .rd_data    (arr_rd_data),
    .rd_tag     (arr_rd_tag),
    .rd_valid   (arr_rd_valid),
    .wr_en      (arr_wr_en),
    .wr_index   (idx_sel),
    .wr_word    (arr_wr_word),
    .wr_data    (arr_wr_data),
    .wr_be      (arr_wr_be),
    .line_set   (arr_line_set),
    .line_clr   (arr_line_clr),
    .clr_all    (1'b0),
    .line_index (idx_sel),
    .line_tag   (tag_sel)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wlen_d       = wlen_q;
    beat_d       = beat_q;
    rdata_d      = rdata_q;
    rvalid_d     = 1'b0;
    wdone_d      = 1'b0;
    req_valid_d  = req_valid_q;
    req_write_d  = req_write_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_wstrb_d  = req_wstrb_q;
    arr_wr_en    = 1'b0;
    arr_wr_word  = word_sel;
    arr_wr_data  = st_data;
    arr_wr_be    = st_be;
    arr_line_set = 1'b0;
    arr_line_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dc_en) begin
          addr_d  = dc_in_addr;
          we_d    = dc_write_en;
          wdata_d = dc_in_wdata;
          wlen_d  = dc_in_wlen;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (we_q) begin
          // Write-through: a hit updates the cached copy, memory always gets the store.
          arr_wr_en   = hit;
          req_valid_d = 1'b1;
          req_write_d = 1'b1;
          req_addr_d  = dw_addr;
          req_wdata_d = st_data;
          req_wstrb_d = st_be;
          state_d     = WR_REQ;
        end else if (hit) begin
          rdata_d  = arr_rd_data;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end else begin
          // The victim line is invalidated before its words are overwritten.
          arr_line_clr = 1'b1;
          req_valid_d  = 1'b1;
          req_write_d  = 1'b0;
          req_addr_d   = line_addr;
          req_wdata_d  = '0;
          req_wstrb_d  = '0;
          beat_d       = '0;
          state_d      = FILL_REQ;
        end
      end
      FILL_REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = FILL_DATA;
        end
      end
      FILL_DATA: begin
        if (mem_rvalid) begin
          arr_wr_en   = 1'b1;
          arr_wr_word = beat_q;
          arr_wr_data = mem_rdata;
          arr_wr_be   = '1;
          if (beat_q == word_sel) begin
            rdata_d = mem_rdata;
          end
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            arr_line_set = 1'b1;
            rvalid_d     = 1'b1;
            state_d      = RESP;
          end
        end
      end
      WR_REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (mem_wack) begin
          wdone_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wlen_q      <= WLEN_B;
      beat_q      <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      wdone_q     <= 1'b0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wlen_q      <= wlen_d;
      beat_q      <= beat_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      wdone_q     <= wdone_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && state_q == IDLE && dc_en) begin
      assert (!misaligned(dc_in_wlen, dc_in_addr[2:0]))
        else $error("dcache_ctrl: misaligned access addr=%h wlen=%0d", dc_in_addr, dc_in_wlen);
    end
  end

  assign dc_out_rdata      = rdata_q;
  assign dc_out_rvalid     = rvalid_q;
  assign dc_out_write_done = wdone_q;
  assign mem_req_valid     = req_valid_q;
  assign mem_req_write     = req_write_q;
  assign mem_req_addr      = req_addr_q;
  assign mem_req_wdata     = req_wdata_q;
  assign mem_req_wstrb     = req_wstrb_q;

endmodule
